cache_line_sel: RTL and testbench



---
 rtl/cache_line_sel.sv | 138 +++++++++++++
 tb/tb_cache_line_sel.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_sel.sv
// cache_line_sel: registered one-hot line selector with a sequential flush sweep.
// Decodes an IDX_W-bit line index into a DEPTH-wide one-hot select (1-cycle latency).
// On sweep_req it walks every line 0..DEPTH-1, one per cycle, then pulses sweep_done.
// Optional feature macro: CACHE_LINE_SEL_ERR_EN enables the sticky out-of-range flag
// on err; without it err is tied low.
module cache_line_sel #(
   parameter int IDX_W = 7,
   parameter int DEPTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             sweep_req,
   output logic             out_vld,
   output logic [DEPTH-1:0] out_sel,
   output logic [IDX_W-1:0] out_idx,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic             err
);

   // Counter is one bit wider than the index so it can hold DEPTH itself.
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);
   localparam logic [IDX_W:0] CNT_ZERO = (IDX_W+1)'(0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e           state_q;
   logic [IDX_W:0]   cnt_q;
   logic             out_vld_q;
   logic [DEPTH-1:0] out_sel_q;
   logic [IDX_W-1:0] out_idx_q;
   logic             sweep_done_q;
   logic             in_oor_d;
   logic             accept_idle_d;

   // One-hot decode of a (possibly out-of-range) line number; no bit set when idx >= DEPTH.
   function automatic logic [DEPTH-1:0] onehot(input logic [IDX_W:0] idx);
      logic [DEPTH-1:0] sel;
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel[i] = (idx == (IDX_W+1)'(i));
      end
      return sel;
   endfunction

   assign in_oor_d      = ({1'b0, in_idx} >= DEPTH_C);
   assign accept_idle_d = (state_q == ST_IDLE) || (state_q == ST_DONE);

   // Main FSM: decode requests in IDLE/DONE, walk lines in SWEEP; all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         out_vld_q    <= 1'b0;
         out_sel_q    <= '0;
         out_idx_q    <= '0;
         sweep_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               sweep_done_q <= 1'b0;
               if (sweep_req) begin
                  // Sweep wins over a simultaneous decode; the decode is dropped.
                  state_q   <= ST_SWEEP;
                  out_sel_q <= onehot(CNT_ZERO);
                  out_idx_q <= '0;
                  out_vld_q <= 1'b1;
                  cnt_q     <= CNT_ONE;
               end else begin
                  state_q <= ST_IDLE;
                  if (in_vld) begin
                     out_vld_q <= 1'b1;
                     out_idx_q <= in_idx;
                     if (in_oor_d) begin
                        out_sel_q <= '0;
                     end else begin
                        out_sel_q <= onehot({1'b0, in_idx});
                     end
                  end else begin
                     out_vld_q <= 1'b0;
                  end
               end
            end
            ST_SWEEP: begin
               if (cnt_q < DEPTH_C) begin
                  out_sel_q <= onehot(cnt_q);
                  out_idx_q <= cnt_q[IDX_W-1:0];
                  out_vld_q <= 1'b1;
                  cnt_q     <= cnt_q + CNT_ONE;
               end else begin
                  // Last line already presented; counter parks at DEPTH.
                  out_vld_q    <= 1'b0;
                  sweep_done_q <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               out_vld_q    <= 1'b0;
               sweep_done_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef CACHE_LINE_SEL_ERR_EN
   logic err_q;

   // Sticky flag: set by any accepted out-of-range decode, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept_idle_d && !sweep_req && in_vld && in_oor_d) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign out_vld    = out_vld_q;
   assign out_sel    = out_sel_q;
   assign out_idx    = out_idx_q;
   assign sweep_done = sweep_done_q;
   assign sweep_busy = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_cache_line_sel.sv
// Self-checking bench for cache_line_sel: table vectors, directed sweep/abort/priority
// sequences, a DEPTH=100 instance for range/err behaviour, and randomized traffic
// against an edge-indexed behavioural model.
module tb_cache_line_sel;

   localparam int D = 128;
   localparam int DB = 100;
`ifdef CACHE_LINE_SEL_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_vld = 1'b0;
   logic [6:0]     in_idx = 7'd0;
   logic           sweep_req = 1'b0;

   logic           out_vld, sweep_busy, sweep_done, err;
   logic [D-1:0]   out_sel;
   logic [6:0]     out_idx;
   logic           b_vld, b_busy, b_done, b_err;
   logic [DB-1:0]  b_sel;
   logic [6:0]     b_idx;

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model state
   int           edge_n;
   bit           m_act;
   int           m_s0;
   logic         m_vld, m_busy, m_done, m_err;
   logic [D-1:0] m_sel;
   logic [6:0]   m_idx;
   logic [D-1:0] one128;

   always #5 clk = ~clk;

   cache_line_sel #(.IDX_W(7), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_idx(in_idx), .sweep_req(sweep_req),
      .out_vld(out_vld), .out_sel(out_sel), .out_idx(out_idx),
      .sweep_busy(sweep_busy), .sweep_done(sweep_done), .err(err)
   );

   cache_line_sel #(.IDX_W(7), .DEPTH(DB)) dut100 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_idx(in_idx), .sweep_req(sweep_req),
      .out_vld(b_vld), .out_sel(b_sel), .out_idx(b_idx),
      .sweep_busy(b_busy), .sweep_done(b_done), .err(b_err)
   );

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_act  = 1'b0;
      m_s0   = 0;
      m_vld  = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_sel  = '0;
      m_idx  = 7'd0;
   endtask

   task automatic check_model();
      chk("vld",  {{(D-1){1'b0}}, out_vld},    {{(D-1){1'b0}}, m_vld});
      chk("sel",  out_sel, m_sel);
      chk("idx",  {{(D-7){1'b0}}, out_idx},    {{(D-7){1'b0}}, m_idx});
      chk("busy", {{(D-1){1'b0}}, sweep_busy}, {{(D-1){1'b0}}, m_busy});
      chk("done", {{(D-1){1'b0}}, sweep_done}, {{(D-1){1'b0}}, m_done});
      chk("err",  {{(D-1){1'b0}}, err},        {{(D-1){1'b0}}, m_err});
   endtask

   // one clock: drive, edge, advance model, sample on the falling edge, compare
   task automatic step(input logic sw, input logic v, input logic [6:0] ix);
      int off;
      sweep_req = sw;
      in_vld    = v;
      in_idx    = ix;
      @(posedge clk);
      edge_n++;
      if (!(m_act && (edge_n <= m_s0 + D))) begin
         m_done = 1'b0;
         m_busy = 1'b0;
         if (sw) begin
            m_act = 1'b1;
            m_s0  = edge_n;
         end else if (v) begin
            m_vld = 1'b1;
            m_idx = ix;
            m_sel = (int'(ix) < D) ? (one128 << ix) : '0;
            if (int'(ix) >= D && ERR_EXP) m_err = 1'b1;
         end else begin
            m_vld = 1'b0;
         end
      end
      if (m_act) begin
         off = edge_n - m_s0;
         if (off < D) begin
            m_vld  = 1'b1;
            m_idx  = 7'(off);
            m_sel  = one128 << off;
            m_busy = 1'b1;
            m_done = 1'b0;
         end else if (off == D) begin
            m_vld  = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_model();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sweep_req = 1'b0;
      in_vld = 1'b0;
   endtask

   typedef struct {
      logic       vld;
      logic [6:0] idx;
      logic       exp_vld;
      logic [6:0] exp_idx;
      logic       exp_hot;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int busy_cnt, done_cnt;
      one128 = {{(D-1){1'b0}}, 1'b1};
      edge_n = 0;
      model_reset();

      vecs[0] = '{1'b1, 7'h05, 1'b1, 7'h05, 1'b1};
      vecs[1] = '{1'b1, 7'h00, 1'b1, 7'h00, 1'b1};
      vecs[2] = '{1'b1, 7'h7F, 1'b1, 7'h7F, 1'b1};
      vecs[3] = '{1'b1, 7'h40, 1'b1, 7'h40, 1'b1};
      vecs[4] = '{1'b0, 7'h03, 1'b0, 7'h40, 1'b1};
      vecs[5] = '{1'b1, 7'h21, 1'b1, 7'h21, 1'b1};
      vecs[6] = '{1'b1, 7'h7E, 1'b1, 7'h7E, 1'b1};
      vecs[7] = '{1'b0, 7'h00, 1'b0, 7'h7E, 1'b1};

      // reset state
      do_reset();
      chk("reset_vld", {{(D-1){1'b0}}, out_vld}, '0);
      chk("reset_sel", out_sel, '0);

      // table-driven decodes
      for (int i = 0; i < 8; i++) begin
         step(1'b0, vecs[i].vld, vecs[i].idx);
         chk($sformatf("tbl%0d_vld", i), {{(D-1){1'b0}}, out_vld}, {{(D-1){1'b0}}, vecs[i].exp_vld});
         chk($sformatf("tbl%0d_idx", i), {{(D-7){1'b0}}, out_idx}, {{(D-7){1'b0}}, vecs[i].exp_idx});
         chk($sformatf("tbl%0d_sel", i), out_sel, vecs[i].exp_hot ? (one128 << vecs[i].exp_idx) : '0);
      end

      // full sweep with decode requests interleaved (must be ignored)
      busy_cnt = 0;
      done_cnt = 0;
      step(1'b1, 1'b0, 7'd0);
      chk("sweep_first_idx", {{(D-7){1'b0}}, out_idx}, '0);
      busy_cnt += int'(sweep_busy);
      for (int k = 1; k <= D + 2; k++) begin
         step(1'b0, 1'b1, 7'($urandom_range(0, 127)));
         busy_cnt += int'(sweep_busy);
         done_cnt += int'(sweep_done);
         if (k == D) chk("sweep_done_vld", {{(D-1){1'b0}}, out_vld}, '0);
      end
      chk("sweep_busy_cycles", D'(busy_cnt), D'(D));
      chk("sweep_done_pulses", D'(done_cnt), D'(1));

      // priority: sweep beats simultaneous decode of 9
      step(1'b0, 1'b0, 7'd0);
      step(1'b1, 1'b1, 7'd9);
      chk("prio_idx", {{(D-7){1'b0}}, out_idx}, '0);
      chk("prio_sel", out_sel, one128);

      // abort at line 50, then restart from 0
      for (int k = 1; k <= 50; k++) step(1'b0, 1'b0, 7'd0);
      chk("abort_pre_idx", {{(D-7){1'b0}}, out_idx}, D'(50));
      do_reset();
      chk("abort_busy", {{(D-1){1'b0}}, sweep_busy}, '0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 7'd0);
      step(1'b1, 1'b0, 7'd0);
      chk("restart_idx", {{(D-7){1'b0}}, out_idx}, '0);
      step(1'b0, 1'b0, 7'd0);
      chk("restart_idx1", {{(D-7){1'b0}}, out_idx}, D'(1));

      // DEPTH=100 instance: out-of-range decode, err stickiness, sweep end
      do_reset();
      step(1'b0, 1'b1, 7'd120);
      chk("d100_oor_vld", {{(D-1){1'b0}}, b_vld}, D'(1));
      chk("d100_oor_sel", {{(D-DB){1'b0}}, b_sel}, '0);
      chk("d100_oor_err", {{(D-1){1'b0}}, b_err}, {{(D-1){1'b0}}, ERR_EXP});
      step(1'b0, 1'b1, 7'd99);
      chk("d100_top_sel", {{(D-DB){1'b0}}, b_sel}, one128 << 99);
      busy_cnt = 0;
      done_cnt = 0;
      step(1'b1, 1'b0, 7'd0);
      busy_cnt += int'(b_busy);
      for (int k = 1; k <= DB + 1; k++) begin
         step(1'b0, 1'b0, 7'd0);
         busy_cnt += int'(b_busy);
         done_cnt += int'(b_done);
         if (k == DB - 1) chk("d100_last_idx", {{(D-7){1'b0}}, b_idx}, D'(DB - 1));
         if (k == DB) chk("d100_done_vld", {{(D-1){1'b0}}, b_vld}, '0);
      end
      chk("d100_busy_cycles", D'(busy_cnt), D'(DB));
      chk("d100_done_pulses", D'(done_cnt), D'(1));
      chk("d100_err_sticky", {{(D-1){1'b0}}, b_err}, {{(D-1){1'b0}}, ERR_EXP});
      do_reset();
      chk("d100_err_cleared", {{(D-1){1'b0}}, b_err}, '0);

      // randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
              7'($urandom_range(0, 127)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
